video_rect_measure: RTL and testbench
=====================================

VIDEO_RECT_MEASURE -- requirements
Module: video_rect_measure

Interface
REQ-001 Parameter: CORDW, 10, coordinate width.
REQ-002 Parameter: H_RES, 640, active pixels per line.
REQ-003 Parameter: V_RES, 480, active lines per frame.
REQ-004 Parameter: KEY_R / KEY_G / KEY_B, 8'hFF each, colour counted as "match".
REQ-005 clk_pix  in  1  pixel clock; the sole clock.
REQ-006 rst_pix  in  1  reset, synchronous, active-high.
REQ-007 vid_sx / vid_sy  in  CORDW each  pixel coordinates of the incoming stream.
REQ-008 vid_de  in  1  data enable; low in the blanking interval.
REQ-009 vid_r / vid_g / vid_b  in  8 each  pixel colour.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  consumer accepts the result.
REQ-012 res_found  out  1  at least one matching pixel in the frame.
REQ-013 res_xmin / res_xmax / res_ymin / res_ymax  out  CORDW each  bounding box of matching pixels, inclusive.
REQ-014 res_count  out  20  matching-pixel count.
REQ-015 overrun  out  1  sticky: a result was dropped.
REQ-016 frame_err  out  1  sticky: malformed frame detected.

Function
REQ-017 A pixel SHALL be active when vid_de=1; it SHALL match when active and {vid_r,vid_g,vid_b}={KEY_R,KEY_G,KEY_B}.
REQ-018 The FSM SHALL have the states IDLE and MEASURE; it SHALL leave reset in IDLE.
REQ-019 IDLE->MEASURE SHALL occur on the frame-start pixel (vid_de=1, vid_sx=0, vid_sy=0), and accumulation SHALL include that pixel.
REQ-020 In MEASURE, each matching pixel SHALL update the min/max registers and increment the count.
REQ-021 The first match in a frame SHALL load min and max directly; later matches SHALL be compared unsigned.
REQ-022 The end-of-frame pixel is defined as vid_de=1, vid_sx=H_RES-1, vid_sy=V_RES-1.
REQ-023 The end-of-frame pixel SHALL be included in the frame's accumulation.
REQ-024 On the end-of-frame pixel, the result registers SHALL load on that clock edge, res_valid SHALL assert on the same edge (one-cycle latency), and the FSM SHALL return to IDLE.
REQ-025 If a frame has no match, res_found=0 and res_count=0, and all four bound outputs SHALL be 0.
REQ-026 Result outputs SHALL hold stable while res_valid=1 and res_ready=0.
REQ-027 res_valid SHALL clear on the cycle after res_valid and res_ready are both high, unless a new result loads on that same edge, in which case res_valid stays 1 and the outputs take the new values.
REQ-028 If a new result arrives while res_valid=1 and res_ready=0, the old result SHALL be overwritten and overrun SHALL be set.
REQ-029 A frame-start pixel seen in MEASURE (end-of-frame missed) SHALL set frame_err and restart accumulation from that pixel.
REQ-030 In MEASURE, a line's active-pixel run length differing from H_RES SHALL set frame_err, checked on the de falling edge; the frame still reports at end-of-frame.
REQ-031 res_count SHALL saturate at 2^20-1.
REQ-032 overrun and frame_err SHALL clear only on reset.

Reset
REQ-033 rst_pix SHALL drive all of the following to 0 on the next edge: res_valid, res_found, all bounds, res_count, overrun, frame_err, and every accumulator.
REQ-034 The FSM SHALL go to IDLE on that same edge.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; measurement SHALL resume at the next frame-start pixel.

Structure
REQ-036 A shared package video_pkg SHALL hold the FSM state enum and a measurement-result struct (found, bounds, count).
REQ-037 One sub-module, axis_bounds (running min/max with first-load, CORDW wide), SHALL be instantiated twice, once for x and once for y.

Verification
REQ-038 Generator frame, white at 100<sx<540 and 100<sy<380, else 1/3/7 colour, res_ready=1 -> one res_valid pulse per frame; found=1, x 101..539, y 101..379, count=122481, no flags.
REQ-039 All-blue frame -> found=0, count=0, bounds=0.
REQ-040 Single white pixel at (639,479) -> bounds 639/639/479/479, count=1, valid the edge after that pixel.
REQ-041 res_ready=0 for two frames -> first result held stable, overrun=1 after the second frame, outputs show the second frame.
REQ-042 Stream restarted at (0,0) mid-frame -> frame_err=1, the next complete frame reports correctly.
REQ-043 rst_pix pulse at line 200 -> all outputs 0 on the next edge, no result for that frame, next frame correct.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the rectangle measurement block: FSM states and the
// per-frame measurement result bundle.
package video_pkg;

  localparam int COORD_MAX_W = 16;
  localparam int COUNT_W     = 20;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  typedef struct packed {
    logic                   found;
    logic [COORD_MAX_W-1:0] xmin;
    logic [COORD_MAX_W-1:0] xmax;
    logic [COORD_MAX_W-1:0] ymin;
    logic [COORD_MAX_W-1:0] ymax;
    logic [COUNT_W-1:0]     count;
  } meas_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_bounds.sv
// Running min/max tracker for one coordinate axis. The first sample of a
// frame loads both bounds; later samples widen them (unsigned compare).
module axis_bounds #(
  parameter int CORDW = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             clr,
  input  logic             upd,
  input  logic             first,
  input  logic [CORDW-1:0] coord,
  output logic [CORDW-1:0] cmin,
  output logic [CORDW-1:0] cmax,
  output logic [CORDW-1:0] nxt_min,
  output logic [CORDW-1:0] nxt_max
);

  // nxt_* are exposed so the parent can capture the bound including the
  // sample presented on this very edge.
  always_comb begin
    nxt_min = cmin;
    nxt_max = cmax;
    if (upd) begin
      if (first) begin
        nxt_min = coord;
        nxt_max = coord;
      end else begin
        if (coord < cmin) nxt_min = coord;
        if (coord > cmax) nxt_max = coord;
      end
    end else if (clr) begin
      nxt_min = '0;
      nxt_max = '0;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cmin <= '0;
      cmax <= '0;
    end else begin
      cmin <= nxt_min;
      cmax <= nxt_max;
    end
  end

endmodule

// File: rtl/video_rect_measure.sv
// Measures the bounding box and pixel count of key-coloured pixels in each
// video frame and hands the result out over a valid/ready interface.
module video_rect_measure
  import video_pkg::*;
#(
  parameter int         CORDW = 10,
  parameter int         H_RES = 640,
  parameter int         V_RES = 480,
  parameter logic [7:0] KEY_R = 8'hFF,
  parameter logic [7:0] KEY_G = 8'hFF,
  parameter logic [7:0] KEY_B = 8'hFF
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic [CORDW-1:0]   vid_sx,
  input  logic [CORDW-1:0]   vid_sy,
  input  logic               vid_de,
  input  logic [7:0]         vid_r,
  input  logic [7:0]         vid_g,
  input  logic [7:0]         vid_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic [CORDW-1:0]   res_xmin,
  output logic [CORDW-1:0]   res_xmax,
  output logic [CORDW-1:0]   res_ymin,
  output logic [CORDW-1:0]   res_ymax,
  output logic [COUNT_W-1:0] res_count,
  output logic               overrun,
  output logic               frame_err
);

  localparam int RUN_W = CORDW + 1;

  state_t state, state_nxt;

  logic               frame_start, frame_end, pix_match;
  logic               accumulate, upd, first, result_load;
  logic               restart_err, line_err;
  logic               acc_found, acc_found_nxt;
  logic [COUNT_W-1:0] acc_count, acc_count_nxt;
  logic [CORDW-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
  logic [CORDW-1:0]   xmin_n, xmax_n, ymin_n, ymax_n;
  logic               de_q;
  logic [RUN_W-1:0]   run_len;
  meas_t              res_q, res_nxt;

  assign frame_start = vid_de && (vid_sx == '0) && (vid_sy == '0);
  assign frame_end   = vid_de && (vid_sx == CORDW'(H_RES - 1)) && (vid_sy == CORDW'(V_RES - 1));
  assign pix_match   = vid_de && ({vid_r, vid_g, vid_b} == {KEY_R, KEY_G, KEY_B});

  // The frame-start pixel belongs to the new frame even when seen in IDLE.
  assign accumulate  = (state == ST_MEASURE) || frame_start;
  assign upd         = accumulate && pix_match;
  assign first       = frame_start || !acc_found;
  assign result_load = accumulate && frame_end;
  assign line_err    = (state == ST_MEASURE) && de_q && !vid_de && (run_len != RUN_W'(H_RES));

  always_ff @(posedge clk_pix) begin
    if (rst_pix) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    restart_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start && !frame_end) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (frame_start) restart_err = 1'b1;
        if (frame_end)   state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  axis_bounds #(.CORDW(CORDW)) u_xb (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .clr     (frame_start),
    .upd     (upd),
    .first   (first),
    .coord   (vid_sx),
    .cmin    (xmin_q),
    .cmax    (xmax_q),
    .nxt_min (xmin_n),
    .nxt_max (xmax_n)
  );

  axis_bounds #(.CORDW(CORDW)) u_yb (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .clr     (frame_start),
    .upd     (upd),
    .first   (first),
    .coord   (vid_sy),
    .cmin    (ymin_q),
    .cmax    (ymax_q),
    .nxt_min (ymin_n),
    .nxt_max (ymax_n)
  );

  always_comb begin
    acc_found_nxt = acc_found | upd;
    acc_count_nxt = upd ? sat_inc(acc_count) : acc_count;
    if (frame_start) begin
      acc_found_nxt = pix_match;
      acc_count_nxt = {{(COUNT_W-1){1'b0}}, pix_match};
    end
  end

  always_comb begin
    res_nxt       = '0;
    res_nxt.found = acc_found_nxt;
    res_nxt.xmin  = COORD_MAX_W'(xmin_n);
    res_nxt.xmax  = COORD_MAX_W'(xmax_n);
    res_nxt.ymin  = COORD_MAX_W'(ymin_n);
    res_nxt.ymax  = COORD_MAX_W'(ymax_n);
    res_nxt.count = acc_count_nxt;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      acc_found <= 1'b0;
      acc_count <= '0;
      de_q      <= 1'b0;
      run_len   <= '0;
    end else begin
      acc_found <= acc_found_nxt;
      acc_count <= acc_count_nxt;
      de_q      <= vid_de;
      if (vid_de) begin
        if (!de_q)          run_len <= RUN_W'(1);
        else if (!(&run_len)) run_len <= run_len + RUN_W'(1);
      end
    end
  end

  // A load on the same edge as a handshake keeps valid high with new data.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      res_q     <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (result_load) begin
        res_q     <= res_nxt;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (restart_err || line_err) frame_err <= 1'b1;
    end
  end

  assign res_found = res_q.found;
  assign res_xmin  = res_q.xmin[CORDW-1:0];
  assign res_xmax  = res_q.xmax[CORDW-1:0];
  assign res_ymin  = res_q.ymin[CORDW-1:0];
  assign res_ymax  = res_q.ymax[CORDW-1:0];
  assign res_count = res_q.count;

  logic unused_res_hi;
  assign unused_res_hi = ^{res_q.xmin, res_q.xmax, res_q.ymin, res_q.ymax,
                           xmin_q, xmax_q, ymin_q, ymax_q};

endmodule

// File: tb/tb_video_rect_measure.sv
// Directed bench for video_rect_measure on a reduced 16x12 raster.
module tb_video_rect_measure;

  localparam int CORDW = 10;
  localparam int H_RES = 16;
  localparam int V_RES = 12;
  localparam int HB    = 4;
  localparam int VB    = 2;

  logic             clk_pix = 1'b0;
  logic             rst_pix;
  logic [CORDW-1:0] vid_sx, vid_sy;
  logic             vid_de;
  logic [7:0]       vid_r, vid_g, vid_b;
  logic             res_valid, res_ready, res_found;
  logic [CORDW-1:0] res_xmin, res_xmax, res_ymin, res_ymax;
  logic [19:0]      res_count;
  logic             overrun, frame_err;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt;
  bit lat_seen;

  video_rect_measure #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .vid_sx    (vid_sx),
    .vid_sy    (vid_sy),
    .vid_de    (vid_de),
    .vid_r     (vid_r),
    .vid_g     (vid_g),
    .vid_b     (vid_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_found (res_found),
    .res_xmin  (res_xmin),
    .res_xmax  (res_xmax),
    .res_ymin  (res_ymin),
    .res_ymax  (res_ymax),
    .res_count (res_count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // mode 0: white box x 4..11, y 3..8 on 01/03/07; 1: all blue;
  // 2: single white at (15,11); 3: as mode 0 but line 2 is one pixel short
  function automatic logic [23:0] colour(input int mode, input int x, input int y);
    case (mode)
      1:       return 24'h0000FF;
      2:       return (x == H_RES-1 && y == V_RES-1) ? 24'hFFFFFF : 24'h0000FF;
      default: return (x > 3 && x < 12 && y > 2 && y < 9) ? 24'hFFFFFF : 24'h010307;
    endcase
  endfunction

  task automatic run_lines(input int mode, input int y0, input int y1, input bit vblank);
    int  ylast;
    bit  is_end;
    logic [23:0] c;
    ylast = vblank ? V_RES + VB - 1 : y1;
    for (int y = y0; y <= ylast; y++) begin
      for (int x = 0; x < H_RES + HB; x++) begin
        vid_sx = CORDW'(x);
        vid_sy = CORDW'(y);
        vid_de = (x < H_RES) && (y <= y1) && (y < V_RES) &&
                 !(mode == 3 && y == 2 && x == H_RES-1);
        c      = colour(mode, x, y);
        {vid_r, vid_g, vid_b} = vid_de ? c : 24'h0;
        is_end = vid_de && x == H_RES-1 && y == V_RES-1;
        tick();
        if (res_valid) pulse_cnt++;
        if (is_end && res_valid) lat_seen = 1'b1;
      end
    end
    vid_de = 1'b0;
  endtask

  task automatic check_res(input string tag, input int found, input int xmn, input int xmx,
                           input int ymn, input int ymx, input int cnt);
    chk({tag, "_found"}, 32'(res_found), 32'(found));
    chk({tag, "_xmin"},  32'(res_xmin),  32'(xmn));
    chk({tag, "_xmax"},  32'(res_xmax),  32'(xmx));
    chk({tag, "_ymin"},  32'(res_ymin),  32'(ymn));
    chk({tag, "_ymax"},  32'(res_ymax),  32'(ymx));
    chk({tag, "_count"}, 32'(res_count), 32'(cnt));
  endtask

  task automatic start_frame_stats();
    pulse_cnt = 0;
    lat_seen  = 1'b0;
  endtask

  initial begin
    rst_pix = 1'b1; res_ready = 1'b1;
    vid_sx = '0; vid_sy = '0; vid_de = 1'b0;
    vid_r = '0; vid_g = '0; vid_b = '0;
    tick(); tick();
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    check_res("rst", 0, 0, 0, 0, 0, 0);
    rst_pix = 1'b0;
    tick();

    // generator box frame
    start_frame_stats();
    run_lines(0, 0, V_RES-1, 1'b1);
    chk("gen_latency", 32'(lat_seen), 1);
    chk("gen_pulses", 32'(pulse_cnt), 1);
    check_res("gen", 1, 4, 11, 3, 8, 48);
    chk("gen_overrun", 32'(overrun), 0);
    chk("gen_frame_err", 32'(frame_err), 0);

    // no matching pixel
    start_frame_stats();
    run_lines(1, 0, V_RES-1, 1'b1);
    chk("blue_pulses", 32'(pulse_cnt), 1);
    check_res("blue", 0, 0, 0, 0, 0, 0);

    // single match on the end-of-frame pixel
    start_frame_stats();
    run_lines(2, 0, V_RES-1, 1'b1);
    chk("single_latency", 32'(lat_seen), 1);
    check_res("single", 1, 15, 15, 11, 11, 1);

    // consumer stalls across two frames
    res_ready = 1'b0;
    run_lines(0, 0, V_RES-1, 1'b1);
    chk("hold_valid", 32'(res_valid), 1);
    chk("hold_overrun0", 32'(overrun), 0);
    run_lines(2, 0, 5, 1'b0);
    check_res("hold_mid", 1, 4, 11, 3, 8, 48);
    run_lines(2, 6, V_RES-1, 1'b1);
    chk("ovr_valid", 32'(res_valid), 1);
    chk("ovr_overrun", 32'(overrun), 1);
    check_res("ovr", 1, 15, 15, 11, 11, 1);
    res_ready = 1'b1;
    tick();
    chk("ovr_drain_valid", 32'(res_valid), 0);
    chk("ovr_sticky", 32'(overrun), 1);

    // stream restarts at (0,0) mid-frame
    start_frame_stats();
    run_lines(1, 0, 4, 1'b0);
    run_lines(0, 0, V_RES-1, 1'b1);
    chk("restart_frame_err", 32'(frame_err), 1);
    chk("restart_pulses", 32'(pulse_cnt), 1);
    check_res("restart", 1, 4, 11, 3, 8, 48);

    // reset pulse mid-frame
    run_lines(0, 0, 5, 1'b0);
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    chk("mrst_valid", 32'(res_valid), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    chk("mrst_frame_err", 32'(frame_err), 0);
    check_res("mrst", 0, 0, 0, 0, 0, 0);
    start_frame_stats();
    run_lines(0, 6, V_RES-1, 1'b1);
    chk("mrst_no_result", 32'(pulse_cnt), 0);
    start_frame_stats();
    run_lines(0, 0, V_RES-1, 1'b1);
    chk("post_rst_pulses", 32'(pulse_cnt), 1);
    check_res("post_rst", 1, 4, 11, 3, 8, 48);
    chk("post_rst_frame_err", 32'(frame_err), 0);

    // one short active line
    start_frame_stats();
    run_lines(3, 0, V_RES-1, 1'b1);
    chk("short_frame_err", 32'(frame_err), 1);
    chk("short_pulses", 32'(pulse_cnt), 1);
    check_res("short", 1, 4, 11, 3, 8, 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
